// File: rtl/serial_div_pkg.sv
// Shared remainder encodings and fixed divisors for the serial divisibility checker.
package serial_div_pkg;

  localparam int DIV_A = 3;
  localparam int DIV_B = 5;

  // Each enumerator's value is the remainder it stands for.
  typedef enum logic [1:0] {
    REM3_R0 = 2'd0,
    REM3_R1 = 2'd1,
    REM3_R2 = 2'd2
  } rem3_t;

  typedef enum logic [2:0] {
    REM5_R0 = 3'd0,
    REM5_R1 = 3'd1,
    REM5_R2 = 3'd2,
    REM5_R3 = 3'd3,
    REM5_R4 = 3'd4
  } rem5_t;

endpackage

// File: rtl/serial_mod_fsm.sv
// Moore remainder FSM: state holds N mod DIVISOR for an MSB-first bit stream.
module serial_mod_fsm
  import serial_div_pkg::*;
#(
  parameter int DIVISOR = 3,
  localparam int W = $clog2(DIVISOR)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_i,
  output logic         div_o,
  output logic [W-1:0] rem_o
);

  logic [W-1:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  generate
    if (DIVISOR == DIV_A) begin : g_mod3
      rem3_t cur, nxt;
      assign cur = rem3_t'(state_q);
      always_comb begin
        nxt = REM3_R0;
        case (cur)
          REM3_R0: nxt = bit_i ? REM3_R1 : REM3_R0;
          REM3_R1: nxt = bit_i ? REM3_R0 : REM3_R2;
          REM3_R2: nxt = bit_i ? REM3_R2 : REM3_R1;
          default: nxt = REM3_R0;
        endcase
      end
      assign state_d = W'(nxt);
    end else if (DIVISOR == DIV_B) begin : g_mod5
      rem5_t cur, nxt;
      assign cur = rem5_t'(state_q);
      // Codes 5..7 fall to the default and recover to R0.
      always_comb begin
        nxt = REM5_R0;
        case (cur)
          REM5_R0: nxt = bit_i ? REM5_R1 : REM5_R0;
          REM5_R1: nxt = bit_i ? REM5_R3 : REM5_R2;
          REM5_R2: nxt = bit_i ? REM5_R0 : REM5_R4;
          REM5_R3: nxt = bit_i ? REM5_R2 : REM5_R1;
          REM5_R4: nxt = bit_i ? REM5_R4 : REM5_R3;
          default: nxt = REM5_R0;
        endcase
      end
      assign state_d = W'(nxt);
    end else begin : g_generic
      always_comb begin
        state_d = '0;
        if (int'(state_q) < DIVISOR)
          state_d = W'((2 * int'(state_q) + int'(bit_i)) % DIVISOR);
      end
    end
  endgenerate

  assign div_o = (state_q == '0);
  assign rem_o = state_q;

endmodule

// File: rtl/serial_divisibility_checker.sv
// Streaming divisibility-by-3/5 monitor over an MSB-first serial number.
// Define SERIAL_DIV_REM_OUT_EN to expose the raw remainders on rem3/rem5.
module serial_divisibility_checker
  import serial_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       new_bit,
  output logic       div_by_3,
  output logic       div_by_5
`ifdef SERIAL_DIV_REM_OUT_EN
  ,
  output logic [1:0] rem3,
  output logic [2:0] rem5
`endif
);

  logic [1:0] rem3_w;
  logic [2:0] rem5_w;

  serial_mod_fsm #(.DIVISOR(DIV_A)) u_mod3 (
    .clk   (clk),
    .rst   (rst),
    .bit_i (new_bit),
    .div_o (div_by_3),
    .rem_o (rem3_w)
  );

  serial_mod_fsm #(.DIVISOR(DIV_B)) u_mod5 (
    .clk   (clk),
    .rst   (rst),
    .bit_i (new_bit),
    .div_o (div_by_5),
    .rem_o (rem5_w)
  );

`ifdef SERIAL_DIV_REM_OUT_EN
  assign rem3 = rem3_w;
  assign rem5 = rem5_w;
`else
  logic unused_rem;
  assign unused_rem = ^{rem3_w, rem5_w};
`endif

endmodule

// File: tb/tb_serial_divisibility_checker.sv
// Scoreboard bench: driver pushes expected divisibility after each bit, monitor pops and compares.
module tb_serial_divisibility_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic new_bit = 1'b0;
  logic div_by_3, div_by_5;
`ifdef SERIAL_DIV_REM_OUT_EN
  logic [1:0] rem3;
  logic [2:0] rem5;
`endif

  serial_divisibility_checker dut (
    .clk      (clk),
    .rst      (rst),
    .new_bit  (new_bit),
    .div_by_3 (div_by_3),
    .div_by_5 (div_by_5)
`ifdef SERIAL_DIV_REM_OUT_EN
    ,
    .rem3     (rem3),
    .rem5     (rem5)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic d3;
    logic d5;
    int   r3;
    int   r5;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int pushes = 0;
  int pops = 0;
  int n15 = 0;  // N mod 15 is enough to derive N mod 3 and N mod 5

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: apply inputs away from the edge, advance the reference, queue the expectation.
  task automatic step(input logic r, input logic b);
    exp_t e;
    @(negedge clk);
    rst = r;
    new_bit = b;
    if (r) n15 = 0;
    else   n15 = (2 * n15 + int'(b)) % 15;
    e.id = pushes;
    e.d3 = ((n15 % 3) == 0);
    e.d5 = ((n15 % 5) == 0);
    e.r3 = n15 % 3;
    e.r5 = n15 % 5;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic bits(input logic [31:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) step(1'b0, v[i]);
  endtask

  // Monitor: outputs are Moore, sample shortly after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pops++;
      $display("txn %0d rst=%b bit=%b div3=%b div5=%b exp=%b%b",
               e.id, rst, new_bit, div_by_3, div_by_5, e.d3, e.d5);
      chk($sformatf("div_by_3[%0d]", e.id), {7'd0, div_by_3}, {7'd0, e.d3});
      chk($sformatf("div_by_5[%0d]", e.id), {7'd0, div_by_5}, {7'd0, e.d5});
`ifdef SERIAL_DIV_REM_OUT_EN
      chk($sformatf("rem3[%0d]", e.id), {6'd0, rem3}, 8'(e.r3));
      chk($sformatf("rem5[%0d]", e.id), {5'd0, rem5}, 8'(e.r5));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles, then leading zero keeps N = 0
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    // N = 1, 3
    bits(32'b11, 2);
    // N = 5, 10
    step(1'b1, 1'b0);
    bits(32'b1010, 4);
    // N = 15, 31
    step(1'b1, 1'b0);
    bits(32'b11111, 5);
    // Mid-stream asynchronous reset
    step(1'b1, 1'b0);
    bits(32'b11, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    n15 = 0;
    #1;
    chk("async_rst_div_by_3", {7'd0, div_by_3}, 8'd1);
    chk("async_rst_div_by_5", {7'd0, div_by_5}, 8'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    // Random runs
    for (int run = 0; run < 3; run++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'($urandom_range(0, 1)));
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    chk("pops_match_pushes", 8'(pops), 8'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
